// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through receive FIFO.
// Ports:
//   clk, reset (async, active-high), rxd (raw serial line, idle high)
//   rd_en (pop strobe), rd_data (FIFO head), rx_valid (not empty), rx_count (bytes held)
//   overrun, frame_err (sticky error flags), clr_err (clears both flags)
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rxd,
   input  logic               rd_en,
   output logic [7:0]         rd_data,
   output logic               rx_valid,
   output logic [FIFO_AW:0]   rx_count,
   output logic               overrun,
   output logic               frame_err,
   input  logic               clr_err
);

   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam int DEPTH = 2 ** FIFO_AW;

   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] ONE_BIT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic            sync1;
   logic            rxs;
   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   logic [7:0]      shreg;
   logic            brk;

   logic [FIFO_AW:0] wr_ptr;
   logic [FIFO_AW:0] rd_ptr;
   logic [FIFO_AW:0] count;
   logic [7:0]       mem [DEPTH];

   logic            tick0;
   logic            push;
   logic            ferr_ev;
   logic            full;
   logic            empty;
   logic            pop;
   logic            wr_ok;

   // Two-flop synchronizer; flops reset high so the line looks idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         brk   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  cnt   <= HALF_BIT;
               end
            end
            START: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else if (rxs) begin
                  state <= IDLE;
               end else begin
                  state <= DATA;
                  cnt   <= ONE_BIT;
                  idx   <= 3'd0;
               end
            end
            DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  shreg[idx] <= rxs;
                  cnt        <= ONE_BIT;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               // brk: stop bit was low; hold here until the line idles.
               if (brk) begin
                  if (rxs) begin
                     brk   <= 1'b0;
                     state <= IDLE;
                  end
               end else if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else if (rxs) begin
                  state <= IDLE;
               end else begin
                  brk <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tick0   = (state == STOP) && !brk && (cnt == '0);
   assign push    = tick0 && rxs;
   assign ferr_ev = tick0 && !rxs;

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);
   assign pop   = rd_en && !empty;
   // A pop in the same cycle frees the slot for a push into a full FIFO.
   assign wr_ok = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Set follows clear so a coincident error event leaves the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (clr_err) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
         end
         if (push && full && !pop) begin
            overrun <= 1'b1;
         end
         if (ferr_ev) begin
            frame_err <= 1'b1;
         end
      end
   end

   assign rd_data  = mem[rd_ptr[FIFO_AW-1:0]];
   assign rx_valid = !empty;
   assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized self-checking bench for uart_rx_fifo.
// A byte queue plus two flag bits model the receiver at frame level.
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          rxd;
   logic          rd_en;
   logic          clr_err;
   logic [7:0]    rd_data;
   logic          rx_valid;
   logic [AW:0]   rx_count;
   logic          overrun;
   logic          frame_err;

   uart_rx_fifo #(
      .CLKS_PER_BIT(CPB),
      .FIFO_AW(AW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rxd(rxd),
      .rd_en(rd_en),
      .rd_data(rd_data),
      .rx_valid(rx_valid),
      .rx_count(rx_count),
      .overrun(overrun),
      .frame_err(frame_err),
      .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   rise_cyc = -1;
   logic prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid && !prev_v) rise_cyc <= cyc;
      prev_v <= rx_valid;
   end

   logic [7:0] q[$];
   bit         m_ovr;
   bit         m_ferr;
   int         errors = 0;
   int         checks = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one frame; the start bit begins right after edge c0.
   // The stop bit is preceded by stop_low low cycles. With pop_push,
   // rd_en is high on edge c0+155, the cycle the byte is pushed.
   task automatic send_frame(input logic [7:0] b, input int stop_low,
                             input bit pop_push, output int c0);
      c0 = cyc;
      for (int k = 0; k < 9 * CPB; k++) begin
         rxd = (k < CPB) ? 1'b0 : b[k / CPB - 1];
         tick();
      end
      for (int k = 0; k < stop_low; k++) begin
         rxd = 1'b0;
         tick();
      end
      for (int k = 0; k < CPB; k++) begin
         rxd   = 1'b1;
         rd_en = pop_push && (k == 10);
         tick();
      end
      rd_en = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit good);
      if (!good) m_ferr = 1'b1;
      else if (q.size() < DEPTH) q.push_back(b);
      else m_ovr = 1'b1;
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic clear_flags();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      rxd     = 1'b1;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      checks += 4;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0", rx_valid);
      end
      if (rx_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d want 0", rx_count);
      end
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovr: got %b want 0", overrun);
      end
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ferr: got %b want 0", frame_err);
      end
   endtask

   task automatic test_single();
      int c0;
      rise_cyc = -1;
      send_frame(8'hA5, 0, 1'b0, c0);
      model_frame(8'hA5, 1'b1);
      // start on rxd after c0, +2 sync, +1 seen, +152 to the push edge
      checks += 4;
      if (rise_cyc !== c0 + 3 + CPB / 2 + 9 * CPB) begin
         errors++;
         $display("FAIL rise_time: got %0d want %0d", rise_cyc - c0,
                  3 + CPB / 2 + 9 * CPB);
      end
      if (rd_data !== q[0]) begin
         errors++;
         $display("FAIL single_data: got %h want %h", rd_data, q[0]);
      end
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL single_count: got %0d want %0d", rx_count, q.size());
      end
      if (rx_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_valid: got %b want 1", rx_valid);
      end
      pop_one();
      void'(q.pop_front());
      pop_one();
      checks += 2;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL pop_valid: got %b want 0", rx_valid);
      end
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL empty_pop_count: got %0d want %0d", rx_count, q.size());
      end
   endtask

   task automatic test_random();
      int c0;
      logic [7:0] b;
      for (int i = 0; i < 24; i++) begin
         b = 8'($urandom);
         send_frame(b, 0, 1'b0, c0);
         model_frame(b, 1'b1);
         checks += 2;
         if (rx_count !== 4'(q.size())) begin
            errors++;
            $display("FAIL rnd_count[%0d]: got %0d want %0d", i, rx_count, q.size());
         end
         if (overrun !== m_ovr) begin
            errors++;
            $display("FAIL rnd_ovr[%0d]: got %b want %b", i, overrun, m_ovr);
         end
         repeat ($urandom_range(0, 1)) begin
            if (q.size() > 0) begin
               checks++;
               if (rd_data !== q[0]) begin
                  errors++;
                  $display("FAIL rnd_data[%0d]: got %h want %h", i, rd_data, q[0]);
               end
               void'(q.pop_front());
            end
            pop_one();
         end
      end
      while (q.size() > 0) begin
         checks++;
         if (rd_data !== q[0]) begin
            errors++;
            $display("FAIL rnd_drain: got %h want %h", rd_data, q[0]);
         end
         void'(q.pop_front());
         pop_one();
      end
      clear_flags();
      checks++;
      if (overrun !== m_ovr) begin
         errors++;
         $display("FAIL rnd_clr: got %b want %b", overrun, m_ovr);
      end
   endtask

   task automatic test_fill_overrun();
      int c0;
      for (int i = 1; i <= 8; i++) begin
         send_frame(8'(i), 0, 1'b0, c0);
         model_frame(8'(i), 1'b1);
      end
      checks += 2;
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL fill_count: got %0d want %0d", rx_count, q.size());
      end
      if (overrun !== m_ovr) begin
         errors++;
         $display("FAIL fill_ovr: got %b want %b", overrun, m_ovr);
      end
      send_frame(8'h09, 0, 1'b0, c0);
      model_frame(8'h09, 1'b1);
      checks += 2;
      if (overrun !== m_ovr) begin
         errors++;
         $display("FAIL ovr_set: got %b want %b", overrun, m_ovr);
      end
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL ovr_count: got %0d want %0d", rx_count, q.size());
      end
      while (q.size() > 0) begin
         checks++;
         if (rd_data !== q[0]) begin
            errors++;
            $display("FAIL ovr_order: got %h want %h", rd_data, q[0]);
         end
         void'(q.pop_front());
         pop_one();
      end
      clear_flags();
   endtask

   task automatic test_glitch();
      int c0;
      for (int k = 0; k < 4; k++) begin
         rxd = 1'b0;
         tick();
      end
      rxd = 1'b1;
      repeat (2 * CPB) tick();
      checks += 3;
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL glitch_count: got %0d want %0d", rx_count, q.size());
      end
      if (frame_err !== m_ferr) begin
         errors++;
         $display("FAIL glitch_ferr: got %b want %b", frame_err, m_ferr);
      end
      if (overrun !== m_ovr) begin
         errors++;
         $display("FAIL glitch_ovr: got %b want %b", overrun, m_ovr);
      end
      send_frame(8'h3C, 0, 1'b0, c0);
      model_frame(8'h3C, 1'b1);
      checks += 2;
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL after_glitch_count: got %0d want %0d", rx_count, q.size());
      end
      if (rd_data !== q[0]) begin
         errors++;
         $display("FAIL after_glitch_data: got %h want %h", rd_data, q[0]);
      end
      void'(q.pop_front());
      pop_one();
   endtask

   task automatic test_frame_err();
      int c0;
      send_frame(8'h55, 3 * CPB, 1'b0, c0);
      model_frame(8'h55, 1'b0);
      checks += 2;
      if (frame_err !== m_ferr) begin
         errors++;
         $display("FAIL ferr_set: got %b want %b", frame_err, m_ferr);
      end
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL ferr_count: got %0d want %0d", rx_count, q.size());
      end
      clear_flags();
      checks++;
      if (frame_err !== m_ferr) begin
         errors++;
         $display("FAIL ferr_clr: got %b want %b", frame_err, m_ferr);
      end
      send_frame(8'h66, 0, 1'b0, c0);
      model_frame(8'h66, 1'b1);
      checks += 2;
      if (rd_data !== q[0]) begin
         errors++;
         $display("FAIL ferr_next_data: got %h want %h", rd_data, q[0]);
      end
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL ferr_next_count: got %0d want %0d", rx_count, q.size());
      end
      void'(q.pop_front());
      pop_one();
   endtask

   task automatic test_pop_on_push();
      int c0;
      logic [7:0] b;
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         send_frame(b, 0, 1'b0, c0);
         model_frame(b, 1'b1);
      end
      send_frame(8'h99, 0, 1'b1, c0);
      void'(q.pop_front());
      q.push_back(8'h99);
      checks += 2;
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL pp_count: got %0d want %0d", rx_count, q.size());
      end
      if (overrun !== m_ovr) begin
         errors++;
         $display("FAIL pp_ovr: got %b want %b", overrun, m_ovr);
      end
      while (q.size() > 0) begin
         checks++;
         if (rd_data !== q[0]) begin
            errors++;
            $display("FAIL pp_order: got %h want %h", rd_data, q[0]);
         end
         if (q.size() == 1) begin
            checks++;
            if (rd_data !== 8'h99) begin
               errors++;
               $display("FAIL pp_last: got %h want 99", rd_data);
            end
         end
         void'(q.pop_front());
         pop_one();
      end
   endtask

   task automatic test_reset_mid();
      int c0;
      logic [7:0] b;
      for (int i = 0; i < 2; i++) begin
         b = 8'($urandom);
         send_frame(b, 0, 1'b0, c0);
         model_frame(b, 1'b1);
      end
      send_frame(8'h00, CPB, 1'b0, c0);
      model_frame(8'h00, 1'b0);
      b = 8'($urandom);
      // stop partway into data bit 4
      for (int k = 0; k < 5 * CPB + CPB / 2; k++) begin
         rxd = (k < CPB) ? 1'b0 : b[k / CPB - 1];
         tick();
      end
      reset = 1'b1;
      #1;
      q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      checks++;
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL async_rst_count: got %0d want %0d", rx_count, q.size());
      end
      tick();
      rxd = 1'b1;
      tick();
      reset = 1'b0;
      repeat (2 * CPB) tick();
      checks += 3;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_valid: got %b want 0", rx_valid);
      end
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL mid_rst_count: got %0d want %0d", rx_count, q.size());
      end
      if (frame_err !== m_ferr || overrun !== m_ovr) begin
         errors++;
         $display("FAIL mid_rst_flags: got %b%b want %b%b",
                  frame_err, overrun, m_ferr, m_ovr);
      end
      send_frame(8'hC3, 0, 1'b0, c0);
      model_frame(8'hC3, 1'b1);
      checks += 2;
      if (rd_data !== q[0]) begin
         errors++;
         $display("FAIL mid_rst_next: got %h want %h", rd_data, q[0]);
      end
      if (rx_count !== 4'(q.size())) begin
         errors++;
         $display("FAIL mid_rst_ncount: got %0d want %0d", rx_count, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_random();
      test_fill_overrun();
      test_glitch();
      test_frame_err();
      test_pop_on_push();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
